// File: rtl/gci_std_display_pkg.sv
// gci_std_display_pkg: constants and helpers shared by the display write path
package gci_std_display_pkg;

    localparam int COLOR_W = 24;
    localparam logic [3:0] MEM_BYTEEN = 4'b0111;

    function automatic int unsigned area_size(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// gci_std_display_sync_fifo: circular synchronous FIFO, active-low sync reset
module gci_std_display_sync_fifo #(
    parameter int P_W       = 8,
    parameter int P_DEPTH   = 16,
    parameter int P_DEPTH_N = 4
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 push,
    input  logic                 pop,
    input  logic [P_W-1:0]       wdata,
    output logic [P_W-1:0]       rdata,
    output logic                 full,
    output logic                 empty,
    output logic [P_DEPTH_N:0]   count
);

    localparam logic [P_DEPTH_N:0] L_FULL = (P_DEPTH_N+1)'(P_DEPTH);

    logic [P_W-1:0] mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = count == L_FULL;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge iCLOCK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gci_std_display_vram_writer.sv
// gci_std_display_vram_writer: buffers pixel writes and issues them as VRAM word writes
module gci_std_display_vram_writer
    import gci_std_display_pkg::*;
#(
    parameter int P_AREA_H       = 640,
    parameter int P_AREA_V       = 480,
    parameter int P_MEM_ADDR_N   = 23,
    parameter logic [P_MEM_ADDR_N-1:0] P_BASE_ADDR = '0,
    parameter int P_FIFO_DEPTH   = 16,
    parameter int P_FIFO_DEPTH_N = 4
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    input  logic                    iRESET_SYNC,
    input  logic                    iIF_VALID,
    output logic                    oIF_BUSY,
    input  logic [P_MEM_ADDR_N-1:0] iIF_ADDR,
    input  logic [23:0]             iIF_DATA,
    output logic                    oMEM_VALID,
    input  logic                    iMEM_BUSY,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [31:0]             oMEM_DATA,
    output logic [3:0]              oMEM_BYTEEN,
    output logic                    oIDLE,
    output logic                    oERR
);

    localparam int L_ENT_W = P_MEM_ADDR_N + COLOR_W;
    localparam logic [P_MEM_ADDR_N:0] L_AREA = (P_MEM_ADDR_N+1)'(area_size(P_AREA_H, P_AREA_V));

    logic rst_n, accept, in_range, push, pop, mem_done;
    logic fifo_full, fifo_empty;
    logic [P_FIFO_DEPTH_N:0] fifo_count;
    logic [L_ENT_W-1:0] fifo_rdata;
    logic stage_valid, err;
    logic [P_MEM_ADDR_N-1:0] stage_addr;
    logic [COLOR_W-1:0] stage_data;

    assign rst_n    = inRESET && !iRESET_SYNC;
    assign accept   = iIF_VALID && !fifo_full;
    assign in_range = {1'b0, iIF_ADDR} < L_AREA;
    assign push     = accept && in_range;
    assign mem_done = stage_valid && !iMEM_BUSY;
    assign pop      = !fifo_empty && (!stage_valid || mem_done);

    gci_std_display_sync_fifo #(
        .P_W(L_ENT_W),
        .P_DEPTH(P_FIFO_DEPTH),
        .P_DEPTH_N(P_FIFO_DEPTH_N)
    ) u_fifo (
        .iCLOCK(iCLOCK),
        .inRESET(rst_n),
        .push(push),
        .pop(pop),
        .wdata({P_BASE_ADDR + iIF_ADDR, iIF_DATA}),
        .rdata(fifo_rdata),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // stage holds its contents while the VRAM port stalls
    always_ff @(posedge iCLOCK) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
            err         <= 1'b0;
        end else begin
            if (pop) begin
                stage_valid              <= 1'b1;
                {stage_addr, stage_data} <= fifo_rdata;
            end else if (mem_done) begin
                stage_valid <= 1'b0;
            end
            if (accept && !in_range) err <= 1'b1;
        end
    end

    assign oIF_BUSY    = fifo_full;
    assign oMEM_VALID  = stage_valid;
    assign oMEM_ADDR   = stage_addr;
    assign oMEM_DATA   = {8'h00, stage_data};
    assign oMEM_BYTEEN = MEM_BYTEEN;
    assign oIDLE       = (fifo_count == '0) && !stage_valid;
    assign oERR        = err;

endmodule

// File: tb/tb_gci_std_display_vram_writer.sv
// tb_gci_std_display_vram_writer: vector table plus queue-model checks of the VRAM writer
module tb_gci_std_display_vram_writer;

    localparam int AREA = 640 * 480;

    logic iCLOCK = 1'b0;
    logic inRESET = 1'b0;
    logic iRESET_SYNC = 1'b0;
    logic iIF_VALID = 1'b0;
    logic iMEM_BUSY = 1'b0;
    logic [22:0] iIF_ADDR = '0;
    logic [23:0] iIF_DATA = '0;
    logic oIF_BUSY, oMEM_VALID, oIDLE, oERR;
    logic [22:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic [3:0] oMEM_BYTEEN;

    always #5 iCLOCK = ~iCLOCK;

    gci_std_display_vram_writer dut (
        .iCLOCK(iCLOCK),
        .inRESET(inRESET),
        .iRESET_SYNC(iRESET_SYNC),
        .iIF_VALID(iIF_VALID),
        .oIF_BUSY(oIF_BUSY),
        .iIF_ADDR(iIF_ADDR),
        .iIF_DATA(iIF_DATA),
        .oMEM_VALID(oMEM_VALID),
        .iMEM_BUSY(iMEM_BUSY),
        .oMEM_ADDR(oMEM_ADDR),
        .oMEM_DATA(oMEM_DATA),
        .oMEM_BYTEEN(oMEM_BYTEEN),
        .oIDLE(oIDLE),
        .oERR(oERR)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pending pixels in a queue plus the single presented write
    logic [46:0] fq[$];
    logic [46:0] stage_e;
    bit stage_v = 0;
    bit err_m = 0;
    bit last_acc = 0;
    logic [22:0] wlog[$];

    task automatic cyc(input bit v, input logic [22:0] a, input logic [23:0] d, input bit mb, input bit rst = 0);
        bit full, done, pop_m, inr;
        iIF_VALID = v;
        iIF_ADDR  = a;
        iIF_DATA  = d;
        iMEM_BUSY = mb;
        inRESET   = !rst;
        full  = fq.size() == 16;
        inr   = int'(a) < AREA;
        done  = stage_v && !mb;
        pop_m = fq.size() != 0 && (!stage_v || done);
        last_acc = v && !full && !rst;
        @(posedge iCLOCK);
        #1;
        if (rst) begin
            fq.delete();
            wlog.delete();
            stage_v = 0;
            err_m = 0;
        end else begin
            if (done) wlog.push_back(stage_e[46:24]);
            if (pop_m) begin
                stage_e = fq.pop_front();
                stage_v = 1;
            end else if (done) begin
                stage_v = 0;
            end
            if (last_acc && inr) fq.push_back({a, d});
            if (last_acc && !inr) err_m = 1;
        end
        check("flags", {oIF_BUSY, oMEM_VALID, oIDLE, oERR},
              {fq.size() == 16, stage_v, fq.size() == 0 && !stage_v, err_m});
        if (stage_v) begin
            check("mem_addr", oMEM_ADDR, stage_e[46:24]);
            check("mem_data", oMEM_DATA, {8'h00, stage_e[23:0]});
        end
    endtask

    task automatic stream(input int start, input int n, input bit mb, input int maxc, output int acc);
        acc = 0;
        for (int c = 0; c < maxc && acc < n; c++) begin
            cyc(1'b1, 23'(start + acc), 24'($urandom), mb);
            if (last_acc) acc++;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (fq.size() != 0 || stage_v); c++) cyc(1'b0, '0, '0, 1'b0);
        check("drain_idle", oIDLE, 1);
    endtask

    typedef struct {
        bit rn, rs, v, mb;
        logic [22:0] a;
        logic [23:0] d;
        bit eb, emv, eidle, eerr, ead;
        logic [22:0] eaddr;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int acc, n, inr_cnt, c;
        bit v;
        logic [22:0] a;
        tbl[0]  = '{0, 0, 0, 0, 23'd0, 24'h0, 0, 0, 1, 0, 1, 23'd0, 32'h0};
        tbl[1]  = '{1, 0, 1, 0, 23'd0, 24'hFF8000, 0, 0, 0, 0, 0, 23'd0, 32'h0};
        tbl[2]  = '{1, 0, 0, 0, 23'd0, 24'h0, 0, 1, 0, 0, 1, 23'd0, 32'h00FF8000};
        tbl[3]  = '{1, 0, 0, 0, 23'd0, 24'h0, 0, 0, 1, 0, 0, 23'd0, 32'h0};
        tbl[4]  = '{1, 0, 1, 0, 23'd307200, 24'h123456, 0, 0, 1, 1, 0, 23'd0, 32'h0};
        tbl[5]  = '{1, 0, 0, 0, 23'd0, 24'h0, 0, 0, 1, 1, 0, 23'd0, 32'h0};
        tbl[6]  = '{1, 1, 0, 0, 23'd0, 24'h0, 0, 0, 1, 0, 1, 23'd0, 32'h0};
        tbl[7]  = '{1, 0, 1, 1, 23'd307199, 24'hABCDEF, 0, 0, 0, 0, 0, 23'd0, 32'h0};
        tbl[8]  = '{1, 0, 0, 1, 23'd0, 24'h0, 0, 1, 0, 0, 1, 23'd307199, 32'h00ABCDEF};
        tbl[9]  = '{1, 0, 0, 1, 23'd0, 24'h0, 0, 1, 0, 0, 1, 23'd307199, 32'h00ABCDEF};
        tbl[10] = '{1, 0, 0, 0, 23'd0, 24'h0, 0, 0, 1, 0, 0, 23'd0, 32'h0};
        for (int i = 0; i < 11; i++) begin
            inRESET     = tbl[i].rn;
            iRESET_SYNC = tbl[i].rs;
            iIF_VALID   = tbl[i].v;
            iMEM_BUSY   = tbl[i].mb;
            iIF_ADDR    = tbl[i].a;
            iIF_DATA    = tbl[i].d;
            @(posedge iCLOCK);
            #1;
            check($sformatf("vec%0d_flags", i), {oIF_BUSY, oMEM_VALID, oIDLE, oERR},
                  {tbl[i].eb, tbl[i].emv, tbl[i].eidle, tbl[i].eerr});
            if (tbl[i].ead) begin
                check($sformatf("vec%0d_addr", i), oMEM_ADDR, tbl[i].eaddr);
                check($sformatf("vec%0d_data", i), oMEM_DATA, tbl[i].edata);
                check($sformatf("vec%0d_byteen", i), oMEM_BYTEEN, 4'b0111);
            end
        end
        iRESET_SYNC = 1'b0;

        // stalled burst: 16 buffered plus one presented, then release
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        stream(0, 20, 1'b1, 30, acc);
        check("burst_accept", acc, 17);
        check("burst_busy", oIF_BUSY, 1);
        stream(17, 3, 1'b0, 50, acc);
        check("burst_rest", acc, 3);
        drain();
        check("burst_count", wlog.size(), 20);
        for (int i = 0; i < wlog.size(); i++) check("burst_order", wlog[i], i);

        // random stall pattern with occasional out-of-range indices
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        n = 0;
        inr_cnt = 0;
        c = 0;
        while (n < 100 && c < 3000) begin
            v = $urandom_range(0, 3) != 0;
            a = ($urandom_range(0, 9) == 0) ? 23'(AREA + $urandom_range(0, 1000))
                                            : 23'($urandom_range(0, AREA - 1));
            cyc(v, a, 24'($urandom), 1'($urandom_range(0, 1)));
            if (last_acc) begin
                n++;
                if (int'(a) < AREA) inr_cnt++;
            end
            c++;
        end
        check("rand_accepted", n, 100);
        drain();
        check("rand_writes", wlog.size(), inr_cnt);

        // reset while 8 entries are buffered and a write is presented
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        stream(0, 9, 1'b1, 20, acc);
        check("pre_reset_valid", oMEM_VALID, 1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        check("rst_idle", oIDLE, 1);
        repeat (5) cyc(1'b0, '0, '0, 1'b0);
        check("no_stale", wlog.size(), 0);

        // repeated fill/drain to wrap the pointers, then push+pop at count 15
        for (int r = 0; r < 3; r++) begin
            stream(r * 17, 17, 1'b1, 40, acc);
            check("wrap_fill", acc, 17);
            drain();
        end
        stream(100, 16, 1'b1, 30, acc);
        check("cnt15_fill", acc, 16);
        cyc(1'b1, 23'd200, 24'h55AA55, 1'b0);
        check("cnt15_hold", oIF_BUSY, 0);
        cyc(1'b1, 23'd201, 24'hAA55AA, 1'b1);
        check("cnt15_full", oIF_BUSY, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gci_std_display_vram_writer.md
Name: gci_std_display_vram_writer

Overview:
Sink end of the display pixel-write stream. Accepts per-pixel writes (pixel index + 24-bit RGB) from the character/clear renderers under valid/busy flow control. Buffers the writes in a small FIFO and issues them as 32-bit word writes to the VRAM memory port, converting each pixel index to a VRAM word address. Sits between the display renderers and the memory arbiter.

Parameters:
P_AREA_H, 640, horizontal pixels per frame
P_AREA_V, 480, vertical lines per frame
P_MEM_ADDR_N, 23, pixel-index and VRAM word-address width
P_BASE_ADDR, 0, VRAM word address of pixel 0 (P_MEM_ADDR_N bits)
P_FIFO_DEPTH, 16, write-buffer entries (power of two, >=4)
P_FIFO_DEPTH_N, 4, log2(P_FIFO_DEPTH)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  synchronous active-low reset
iRESET_SYNC  in  1  synchronous soft clear, active-high, same effect as inRESET
iIF_VALID  in  1  pixel write request
oIF_BUSY  out  1  sink cannot accept this cycle
iIF_ADDR  in  P_MEM_ADDR_N  pixel index (y*P_AREA_H + x)
iIF_DATA  in  24  pixel colour {R,G,B}
oMEM_VALID  out  1  VRAM write request
iMEM_BUSY  in  1  VRAM port stall
oMEM_ADDR  out  P_MEM_ADDR_N  VRAM word address
oMEM_DATA  out  32  write data {8'h00, R, G, B}
oMEM_BYTEEN  out  4  byte enables, constant 4'b0111
oIDLE  out  1  FIFO empty and output stage empty
oERR  out  1  sticky: out-of-range pixel index received

Behaviour:
- Reset: inRESET low at a clock edge, or iRESET_SYNC high at a clock edge, clears:
  - FIFO pointers and count to 0
  - output stage valid to 0
  - oERR to 0
- Reset outputs: oIF_BUSY=0, oMEM_VALID=0, oMEM_ADDR=0, oMEM_DATA=0, oIDLE=1, oERR=0.
- Reset mid-transfer discards all buffered and pending writes and drops oMEM_VALID on the next cycle. The memory arbiter tolerates this.
- Input handshake: a transfer occurs in a cycle with iIF_VALID && !oIF_BUSY.
  - oIF_BUSY = (count == P_FIFO_DEPTH), registered-state derived, with no combinational path from iIF_VALID or iMEM_BUSY.
  - When full, no push is taken even if a pop happens in the same cycle.
- Range check at input: if iIF_ADDR >= P_AREA_H*P_AREA_V, the handshake still completes, nothing is pushed, and oERR is set the next cycle and stays set until reset.
- FIFO: circular buffer with wrap-around pointers.
  - count: +1 on push only, -1 on pop only, unchanged when push and pop occur in the same cycle.
  - An entry stores {word address, RGB}, with word address = P_BASE_ADDR + iIF_ADDR computed at push, truncated to P_MEM_ADDR_N bits.
- Output stage: one register holding valid/addr/data.
  - Loads (pops) the FIFO head when the FIFO is non-empty and (stage empty OR oMEM_VALID && !iMEM_BUSY this cycle).
  - If the stage completes a transfer and the FIFO is empty, stage valid goes to 0.
- Memory handshake: a write completes in a cycle with oMEM_VALID && !iMEM_BUSY. While iMEM_BUSY is high, oMEM_VALID, oMEM_ADDR and oMEM_DATA hold stable.
- Latency: input accepted at edge N, pushed at edge N; output loaded at edge N+1; oMEM_VALID high in the cycle after edge N+1.
- Throughput: one pixel per clock sustained while iMEM_BUSY=0.
- Ordering: strictly in acceptance order; no write is merged or dropped except out-of-range writes.
- oIDLE = (count==0) && !stage valid, registered-state derived.

Decomposition:
- Shared package gci_std_display_pkg holds:
  - colour width constant (24)
  - byte-enable constant 4'b0111
  - area-size product P_AREA_H*P_AREA_V as a constant function
- One sub-module: gci_std_display_sync_fifo.
  - Parameterised width/depth, synchronous active-low reset, push/pop/full/empty/count.
  - The FIFO entry is the P_MEM_ADDR_N+24 bit {addr,data} concatenation.

Test Plan:
- After reset, push pixel 0 with RGB 24'hFF8000, iMEM_BUSY=0 -> oMEM_VALID rises 2 edges later with oMEM_ADDR=P_BASE_ADDR, oMEM_DATA=32'h00FF8000, oMEM_BYTEEN=4'b0111; oIDLE returns to 1 one cycle after the transfer.
- Hold iMEM_BUSY=1, stream 20 writes at indices 0..19 -> 17 accepted (16 in FIFO + 1 in output stage), then oIF_BUSY=1; release busy -> exactly 20 memory writes, in order, addresses 0..19, no loss or duplicates.
- iIF_ADDR=307200 (640*480) -> handshake completes, no memory write, oERR=1 and sticky; iRESET_SYNC pulse -> oERR=0.
- Toggle iMEM_BUSY randomly while pushing 100 writes -> memory writes are in order, address/data stable during each stall, and the count never exceeds 16.
- With 8 entries buffered and oMEM_VALID high, assert inRESET low for one edge -> next cycle oMEM_VALID=0, oIDLE=1, oIF_BUSY=0, and no stale writes afterwards.
- Push 17 entries with P_FIFO_DEPTH=16 across several fill/drain cycles -> pointer wrap preserves data; simultaneous push+pop at count 15 keeps count at 15.
